// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit start validation and frame-error strobe
module uart_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       ena,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       bussy
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int HALF = CLKS_PER_BIT / 2;
   localparam logic [TW-1:0] TICK_HALF_LAST = TW'(HALF - 1);
   localparam logic [TW-1:0] TICK_BIT_LAST  = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      sh_q, sh_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            bussy_q, bussy_d;
   logic            rx_m_q, rx_m_d;
   logic            rx_s_q, rx_s_d;
   logic            rx_p_q, rx_p_d;
   logic [1:0]      arm_q, arm_d;
   logic            fall;
   logic            bit_end;

   always_ff @(posedge clk) begin
      if (ena) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         idx_q       <= '0;
         sh_q        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         bussy_q     <= 1'b0;
         rx_m_q      <= 1'b1;
         rx_s_q      <= 1'b1;
         rx_p_q      <= 1'b0;
         arm_q       <= '0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         idx_q       <= idx_d;
         sh_q        <= sh_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         bussy_q     <= bussy_d;
         rx_m_q      <= rx_m_d;
         rx_s_q      <= rx_s_d;
         rx_p_q      <= rx_p_d;
         arm_q       <= arm_d;
      end
   end

   // The synchroniser's reset value of 1 is not a real line level; edge history
   // only starts once rx_s carries a sampled value, so a line that is low when
   // reset drops cannot fake a falling edge.
   always_comb begin
      rx_m_d = rx;
      rx_s_d = rx_m_q;
      arm_d  = {arm_q[0], 1'b1};
      rx_p_d = (arm_q == 2'b11) ? rx_s_q : 1'b0;
   end

   assign fall    = rx_p_q & ~rx_s_q;
   assign bit_end = (tick_q == TICK_BIT_LAST);

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      idx_d   = idx_q;
      sh_d    = sh_q;
      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            if (tick_q == TICK_HALF_LAST) begin
               tick_d  = '0;
               idx_d   = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               tick_d = '0;
               sh_d   = {rx_s_q, sh_q[7:1]};
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               tick_d  = '0;
               state_d = IDLE;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      if (state_q == STOP && bit_end) begin
         if (rx_s_q) begin
            data_d  = sh_q;
            valid_d = 1'b1;
         end else begin
            frame_err_d = 1'b1;
         end
      end
      bussy_d = (state_d != IDLE);
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign bussy     = bussy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       ena = 1'b1;
   logic       rx  = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       bussy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   int         valid_cnt = 0;
   int         fe_cnt    = 0;
   int         bussy_cnt = 0;
   int         both_cnt  = 0;
   int         fe_cyc    = 0;
   int         vcyc[$];
   logic [7:0] vdat[$];

   uart_rx #(.CLKS_PER_BIT(16)) dut (
      .clk       (clk),
      .ena       (ena),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .bussy     (bussy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid) begin
         valid_cnt = valid_cnt + 1;
         vcyc.push_back(cyc);
         vdat.push_back(data);
      end
      if (frame_err) begin
         fe_cnt = fe_cnt + 1;
         fe_cyc = cyc;
      end
      if (bussy) bussy_cnt = bussy_cnt + 1;
      if (valid && frame_err) both_cnt = both_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mon();
      valid_cnt = 0;
      fe_cnt    = 0;
      bussy_cnt = 0;
      fe_cyc    = 0;
      vcyc.delete();
      vdat.delete();
   endtask

   // Called just after a rising edge; e0 is the edge where rx_m first captures the start bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e0);
      rx = 1'b0;
      e0 = cyc + 1;
      tick_n(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick_n(16);
      end
      rx = stop_bit;
      tick_n(16);
   endtask

   initial begin
      int e0;
      int e0a;
      logic [7:0] c3;

      ena = 1'b1;
      rx  = 1'b1;
      tick_n(2);
      ena = 1'b0;
      chk("reset_data", data, 8'h00);
      chk("reset_valid", valid, 1'b0);
      chk("reset_ferr", frame_err, 1'b0);
      chk("reset_bussy", bussy, 1'b0);
      clear_mon();
      tick_n(500);
      chk("idle_valid_cnt", valid_cnt, 0);
      chk("idle_fe_cnt", fe_cnt, 0);
      chk("idle_bussy_cnt", bussy_cnt, 0);
      chk("idle_data", data, 8'h00);

      clear_mon();
      send_frame(8'hA5, 1'b1, e0);
      tick_n(20);
      chk("a5_valid_cnt", valid_cnt, 1);
      chk("a5_valid_cyc", vcyc[0], e0 + 154);
      chk("a5_data", data, 8'hA5);
      chk("a5_bussy_len", bussy_cnt, 152);
      chk("a5_fe_cnt", fe_cnt, 0);

      clear_mon();
      send_frame(8'h00, 1'b1, e0a);
      send_frame(8'hFF, 1'b1, e0);
      send_frame(8'h5A, 1'b1, e0);
      tick_n(20);
      chk("b2b_valid_cnt", valid_cnt, 3);
      chk("b2b_cyc0", vcyc[0], e0a + 154);
      chk("b2b_gap01", vcyc[1] - vcyc[0], 160);
      chk("b2b_gap12", vcyc[2] - vcyc[1], 160);
      chk("b2b_data0", vdat[0], 8'h00);
      chk("b2b_data1", vdat[1], 8'hFF);
      chk("b2b_data2", vdat[2], 8'h5A);
      chk("b2b_fe_cnt", fe_cnt, 0);

      clear_mon();
      rx = 1'b0;
      tick_n(5);
      rx = 1'b1;
      tick_n(40);
      chk("glitch_valid_cnt", valid_cnt, 0);
      chk("glitch_fe_cnt", fe_cnt, 0);
      chk("glitch_bussy_len", bussy_cnt, 8);
      chk("glitch_bussy_now", bussy, 1'b0);
      clear_mon();
      send_frame(8'h3C, 1'b1, e0);
      tick_n(20);
      chk("3c_valid_cnt", valid_cnt, 1);
      chk("3c_valid_cyc", vcyc[0], e0 + 154);
      chk("3c_data", data, 8'h3C);

      clear_mon();
      send_frame(8'h81, 1'b0, e0);
      tick_n(40);
      rx = 1'b1;
      tick_n(20);
      chk("ferr_fe_cnt", fe_cnt, 1);
      chk("ferr_fe_cyc", fe_cyc, e0 + 154);
      chk("ferr_valid_cnt", valid_cnt, 0);
      chk("ferr_data_held", data, 8'h3C);
      chk("ferr_no_false_start", bussy_cnt, 152);
      clear_mon();
      send_frame(8'h42, 1'b1, e0);
      tick_n(20);
      chk("42_valid_cnt", valid_cnt, 1);
      chk("42_data", data, 8'h42);

      clear_mon();
      c3 = 8'hC3;
      rx = 1'b0;
      tick_n(16);
      for (int i = 0; i < 4; i++) begin
         rx = c3[i];
         tick_n(16);
      end
      rx  = c3[4];
      ena = 1'b1;
      tick_n(1);
      ena = 1'b0;
      chk("mrst_bussy", bussy, 1'b0);
      chk("mrst_valid", valid, 1'b0);
      chk("mrst_data", data, 8'h00);
      bussy_cnt = 0;
      tick_n(15);
      for (int i = 5; i < 8; i++) begin
         rx = c3[i];
         tick_n(16);
      end
      rx = 1'b1;
      tick_n(16);
      tick_n(30);
      chk("mrst_valid_cnt", valid_cnt, 0);
      chk("mrst_fe_cnt", fe_cnt, 0);
      chk("mrst_no_restart", bussy_cnt, 0);
      clear_mon();
      send_frame(8'h99, 1'b1, e0);
      tick_n(20);
      chk("99_valid_cnt", valid_cnt, 1);
      chk("99_valid_cyc", vcyc[0], e0 + 154);
      chk("99_data", data, 8'h99);
      chk("never_both", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that sits directly downstream of the UART transmit FSM and consumes its `out` line: 8N1 frames (start bit low, 8 data bits LSB first, stop bit high, idle high). Runs on the system clock with a fixed number of clocks per bit. It synchronises the asynchronous line and validates the start bit at mid-bit. It samples each data bit at its centre and presents the received byte with a one-cycle valid strobe, or a frame-error strobe when the stop bit is bad.

## Interface
- `CLKS_PER_BIT`, 16, clk cycles per serial bit; even, ≥ 4; half-bit = `CLKS_PER_BIT/2`
- `clk`  in  1  system clock, all logic on rising edge
- `ena`  in  1  reset: synchronous, active-high; one clock; clears the block exactly as described under Reset
- `rx`  in  1  serial line, asynchronous to `clk`, idle high
- `data`  out  8  last correctly framed byte; holds until next good frame
- `valid`  out  1  one-cycle pulse, `data` updated in same cycle
- `frame_err`  out  1  one-cycle pulse, stop bit sampled low
- `bussy`  out  1  high while a frame is being received

## Operation
- Synchroniser: two flops `rx_m`→`rx_s`, both reset to 1; only `rx_s` is used internally.
- Counters: bit-time counter `tick`, width `$clog2(CLKS_PER_BIT)`; bit index `idx`, 3 bits; shift register `sh`, 8 bits.
- States: IDLE, START, DATA, STOP.
- IDLE: `bussy`=0. A falling edge on `rx_s` (previous 1, current 0) moves to START with `tick`=0. A line held low, such as a break or the tail of an error frame, does not start a frame until it returns high and falls again.
- START: count to half-bit−1. Then if `rx_s`=0, go to DATA with `tick`=0 and `idx`=0. If `rx_s`=1, this is a false start: return to IDLE with no strobe.
- DATA: at `tick`=CLKS_PER_BIT−1, sample `rx_s` into `sh` LSB-first, i.e. `sh <= {rx_s, sh[7:1]}`, and reset `tick`. After the sample with `idx`=7, go to STOP; otherwise increment `idx`.
- STOP: at `tick`=CLKS_PER_BIT−1, sample `rx_s`:
  - 1: `data <= sh`, `valid`=1 for one cycle.
  - 0: `frame_err`=1 for one cycle; `data` unchanged.
  - Both cases then go to IDLE at the stop-bit centre. This allows a following start bit immediately after a nominal stop bit.
- `valid` and `frame_err` are never high together and are never high for more than one cycle.
- Reset (`ena`=1 at a clock edge), including mid-frame:
  - state returns to IDLE;
  - `tick`, `idx`, `sh`, `data`, `valid`, `frame_err`, `bussy` all go to 0;
  - the synchroniser flops go to 1;
  - the frame in progress is discarded with no strobe.
- `ena` has priority over all other behaviour.

## Timing
- All outputs are registered. Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `bussy`=0.
- Let edge E0 be the first clk edge at which `rx_m` captures 0.
  - `rx_s` goes low at E1; the falling edge is detected at E2, and the state is START after E2.
  - The start check is at E2+half-bit.
  - Data bit k is sampled at E2 + half-bit + (k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at E2 + half-bit + 9·CLKS_PER_BIT. `valid`/`frame_err` are high in the cycle after that edge.
  - With the default of 16: `valid` is high during the cycle following edge E0+154.
- `bussy` rises after E2 and falls in the same cycle that `valid`/`frame_err` is asserted.
- Back-to-back frames with zero idle are received without loss.
- Tolerated bit-rate mismatch: ±(half-bit−1)/(9.5·CLKS_PER_BIT) of the bit period.

## Test plan
- Reset then idle: hold `ena`=1 for 2 cycles, then `rx`=1 for 500 cycles → `data`=8'h00, `valid`/`frame_err`/`bussy` stay 0.
- Single byte 8'hA5, CLKS_PER_BIT=16 → exactly one `valid` pulse in the cycle after E0+154, `data`=8'hA5, `bussy` high for 152 cycles.
- Back-to-back 8'h00, 8'hFF, 8'h5A with no idle bits → three `valid` pulses spaced 160 cycles apart, `data` matches each byte in order.
- Glitch: `rx` low for 5 cycles, then high → no strobe, `bussy` returns to 0 after the start check, next valid frame 8'h3C is received correctly.
- Framing error: send 8'h81 with stop bit driven 0, then hold `rx` low for 40 cycles, then high, then send 8'h42 → one `frame_err`, `data` stays at its prior value, no false start during the low period, then `valid` with `data`=8'h42.
- Mid-frame reset: assert `ena` for 1 cycle after data bit 3 of 8'hC3 → no strobe, `bussy`=0 next cycle; the remaining bits of the aborted frame do not produce a strobe until a fresh falling edge; the following frame 8'h99 is received correctly.
